// File: rtl/multicycle_control_unit.sv
// Multicycle CPU control unit: IDLE/EXEC/MEM_WAIT/WB FSM with BUSYWAIT timeout.
// Define MULTICYCLE_CU_ILLEGAL_TRAP_EN to trap undefined opcodes into a HALT state.
module multicycle_control_unit #(
    parameter int unsigned INSTR_WIDTH    = 32,
    parameter int unsigned OPCODE_WIDTH   = 8,
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned CNT_WIDTH      = 5
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic [INSTR_WIDTH-1:0] INSTRUCTION,
    input  logic                   INSTR_VALID,
    output logic                   INSTR_READY,
    input  logic                   BUSYWAIT,
    output logic                   WRITEENABLE,
    output logic                   SUBSTRACT_SELECT,
    output logic                   IMMEDIATE_SELECT,
    output logic                   BRANCHEQ,
    output logic                   BRANCHNE,
    output logic                   JUMP,
    output logic                   READ,
    output logic                   WRITE,
    output logic [2:0]             ALUOP,
    output logic [1:0]             SHIFTOP,
    output logic                   PC_ENABLE,
    output logic                   TIMEOUT,
    output logic                   ILLEGAL
);

    typedef enum logic [2:0] {
        IDLE,
        EXEC,
        MEM_WAIT,
        WB
`ifdef MULTICYCLE_CU_ILLEGAL_TRAP_EN
        , HALT
`endif
    } state_t;

    typedef struct packed {
        logic       we;
        logic       sub;
        logic       imm;
        logic       beq;
        logic       bne;
        logic       jmp;
        logic       rd;
        logic       wr;
        logic [2:0] aluop;
        logic [1:0] shiftop;
    } ctrl_t;

    state_t                  state, state_n;
    logic [OPCODE_WIDTH-1:0] opcode_q;
    logic [CNT_WIDTH-1:0]    cnt;
    logic                    aborted;
    logic [31:0]             op_num;
    ctrl_t                   dec, ctrl;
    logic                    dec_mem, dec_load, dec_legal;
    logic                    at_limit;
    logic                    pc_en, ready;
    logic                    unused_operand;

    assign unused_operand = ^INSTRUCTION[INSTR_WIDTH-OPCODE_WIDTH-1:0];
    assign op_num   = 32'(opcode_q);
    assign at_limit = (cnt == CNT_WIDTH'(TIMEOUT_CYCLES - 1));

    always_comb begin
        dec       = '0;
        dec_mem   = 1'b0;
        dec_load  = 1'b0;
        dec_legal = 1'b1;
        case (op_num)
            32'h00: begin dec.we = 1'b1; dec.imm = 1'b1; end
            32'h01: dec.we = 1'b1;
            32'h02: begin dec.we = 1'b1; dec.aluop = 3'b001; end
            32'h03: begin dec.we = 1'b1; dec.sub = 1'b1; dec.aluop = 3'b001; end
            32'h04: begin dec.we = 1'b1; dec.aluop = 3'b010; end
            32'h05: begin dec.we = 1'b1; dec.aluop = 3'b011; end
            32'h06: dec.jmp = 1'b1;
            32'h07: begin dec.sub = 1'b1; dec.beq = 1'b1; dec.aluop = 3'b001; end
            32'h08: begin dec.rd = 1'b1; dec_mem = 1'b1; dec_load = 1'b1; end
            32'h09: begin dec.rd = 1'b1; dec.imm = 1'b1; dec_mem = 1'b1; dec_load = 1'b1; end
            32'h0A: begin dec.wr = 1'b1; dec_mem = 1'b1; end
            32'h0B: begin dec.wr = 1'b1; dec.imm = 1'b1; dec_mem = 1'b1; end
            32'h0C: begin dec.sub = 1'b1; dec.bne = 1'b1; dec.aluop = 3'b001; end
            32'h0D: begin dec.we = 1'b1; dec.imm = 1'b1; dec.aluop = 3'b100; dec.shiftop = 2'b00; end
            32'h0E: begin dec.we = 1'b1; dec.imm = 1'b1; dec.aluop = 3'b100; dec.shiftop = 2'b01; end
            32'h0F: begin dec.we = 1'b1; dec.imm = 1'b1; dec.aluop = 3'b100; dec.shiftop = 2'b10; end
            32'h10: begin dec.we = 1'b1; dec.imm = 1'b1; dec.aluop = 3'b100; dec.shiftop = 2'b11; end
            32'h11: begin dec.we = 1'b1; dec.aluop = 3'b101; end
            default: begin dec.aluop = 3'b111; dec_legal = 1'b0; end
        endcase
    end

    always_comb begin
        state_n = state;
        ctrl    = '0;
        pc_en   = 1'b0;
        ready   = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (INSTR_VALID) state_n = EXEC;
            end
            EXEC: begin
                if (dec_mem) begin
                    ctrl    = dec;
                    ctrl.we = 1'b0;
                    state_n = MEM_WAIT;
                end
`ifdef MULTICYCLE_CU_ILLEGAL_TRAP_EN
                else if (!dec_legal) begin
                    state_n = HALT;
                end
`endif
                else begin
                    ctrl    = dec;
                    pc_en   = 1'b1;
                    state_n = IDLE;
                end
            end
            MEM_WAIT: begin
                ctrl    = dec;
                ctrl.we = 1'b0;
                if (!BUSYWAIT || at_limit) state_n = WB;
            end
            WB: begin
                // ALU selects stay stable through write-back; only the memory strobes drop
                ctrl    = dec;
                ctrl.rd = 1'b0;
                ctrl.wr = 1'b0;
                ctrl.we = dec_load && !aborted;
                pc_en   = 1'b1;
                state_n = IDLE;
            end
`ifdef MULTICYCLE_CU_ILLEGAL_TRAP_EN
            HALT: state_n = HALT;
`endif
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state    <= IDLE;
            opcode_q <= '0;
            cnt      <= '0;
            aborted  <= 1'b0;
            TIMEOUT  <= 1'b0;
        end else begin
            state <= state_n;
            case (state)
                IDLE: begin
                    if (INSTR_VALID) begin
                        opcode_q <= INSTRUCTION[INSTR_WIDTH-1 -: OPCODE_WIDTH];
                        aborted  <= 1'b0;
                    end
                end
                EXEC: cnt <= '0;
                MEM_WAIT: begin
                    if (cnt != '1) cnt <= cnt + CNT_WIDTH'(1);
                    if (BUSYWAIT && at_limit) begin
                        aborted <= 1'b1;
                        TIMEOUT <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef MULTICYCLE_CU_ILLEGAL_TRAP_EN
    logic illegal_q;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            illegal_q <= 1'b0;
        end else if (state == EXEC && !dec_legal) begin
            illegal_q <= 1'b1;
        end
    end

    assign ILLEGAL = illegal_q;
`else
    assign ILLEGAL = 1'b0;
`endif

    assign INSTR_READY      = ready;
    assign PC_ENABLE        = pc_en;
    assign WRITEENABLE      = ctrl.we;
    assign SUBSTRACT_SELECT = ctrl.sub;
    assign IMMEDIATE_SELECT = ctrl.imm;
    assign BRANCHEQ         = ctrl.beq;
    assign BRANCHNE         = ctrl.bne;
    assign JUMP             = ctrl.jmp;
    assign READ             = ctrl.rd;
    assign WRITE            = ctrl.wr;
    assign ALUOP            = ctrl.aluop;
    assign SHIFTOP          = ctrl.shiftop;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench for multicycle_control_unit: the driver pushes the expected
// output vector of every cycle, a monitor pops and compares one per cycle.
module tb_multicycle_control_unit;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instruction;
    logic        instr_valid;
    logic        instr_ready;
    logic        busywait;
    logic        writeenable, substract_select, immediate_select;
    logic        brancheq, branchne, jump, read, write;
    logic [2:0]  aluop;
    logic [1:0]  shiftop;
    logic        pc_enable, timeout, illegal;

    multicycle_control_unit #(
        .INSTR_WIDTH(32),
        .OPCODE_WIDTH(8),
        .TIMEOUT_CYCLES(T),
        .CNT_WIDTH(5)
    ) dut (
        .CLK(clk),
        .RESET(reset),
        .INSTRUCTION(instruction),
        .INSTR_VALID(instr_valid),
        .INSTR_READY(instr_ready),
        .BUSYWAIT(busywait),
        .WRITEENABLE(writeenable),
        .SUBSTRACT_SELECT(substract_select),
        .IMMEDIATE_SELECT(immediate_select),
        .BRANCHEQ(brancheq),
        .BRANCHNE(branchne),
        .JUMP(jump),
        .READ(read),
        .WRITE(write),
        .ALUOP(aluop),
        .SHIFTOP(shiftop),
        .PC_ENABLE(pc_enable),
        .TIMEOUT(timeout),
        .ILLEGAL(illegal)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       we, sub, imm, beq, bne, jmp, rd, wr;
        logic [2:0] aluop;
        logic [1:0] shiftop;
        logic       pc, ready, tmo, ill;
    } vec_t;

    vec_t  exp_q[$];
    string tag_q[$];
    int    checks = 0;
    int    errors = 0;
    bit    tmo_m  = 1'b0;

    initial begin
        vec_t  got, exp;
        string tag;
        forever begin
            @(posedge clk);
            #1;
            got = {writeenable, substract_select, immediate_select, brancheq, branchne,
                   jump, read, write, aluop, shiftop, pc_enable, instr_ready, timeout, illegal};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_empty got=%h", got);
            end else begin
                exp = exp_q.pop_front();
                tag = tag_q.pop_front();
                if (got !== exp) begin
                    errors++;
                    $display("FAIL %s got=%h exp=%h (we sub imm beq bne jmp rd wr alu sh pc rdy tmo ill)",
                             tag, got, exp);
                end
            end
        end
    end

    // Architectural meaning of each opcode, straight from the instruction set table.
    function automatic vec_t ref_ctrl(input int op, output bit mem, output bit load);
        vec_t v = '0;
        mem  = 1'b0;
        load = 1'b0;
        case (op)
            0:  begin v.we = 1; v.imm = 1; end
            1:  v.we = 1;
            2:  begin v.we = 1; v.aluop = 3'd1; end
            3:  begin v.we = 1; v.sub = 1; v.aluop = 3'd1; end
            4:  begin v.we = 1; v.aluop = 3'd2; end
            5:  begin v.we = 1; v.aluop = 3'd3; end
            6:  v.jmp = 1;
            7:  begin v.sub = 1; v.beq = 1; v.aluop = 3'd1; end
            8:  begin v.rd = 1; mem = 1; load = 1; end
            9:  begin v.rd = 1; v.imm = 1; mem = 1; load = 1; end
            10: begin v.wr = 1; mem = 1; end
            11: begin v.wr = 1; v.imm = 1; mem = 1; end
            12: begin v.sub = 1; v.bne = 1; v.aluop = 3'd1; end
            13, 14, 15, 16: begin v.we = 1; v.imm = 1; v.aluop = 3'd4; v.shiftop = 2'(op - 13); end
            17: begin v.we = 1; v.aluop = 3'd5; end
            default: v.aluop = 3'd7;
        endcase
        return v;
    endfunction

    function automatic vec_t idle_vec();
        vec_t v = '0;
        v.ready = 1;
        v.tmo   = tmo_m;
        return v;
    endfunction

    task automatic cyc(input bit v, input logic [31:0] ins, input bit b, input bit r,
                       input vec_t e, input string tag);
        reset       = r;
        instr_valid = v;
        instruction = ins;
        busywait    = b;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(negedge clk);
    endtask

    // Noise driven while the unit is busy; it must be ignored.
    task automatic busy_cyc(input vec_t e, input string tag);
        cyc(1'($urandom), $urandom, 1'($urandom), 1'b0, e, tag);
    endtask

    // Issue one instruction from IDLE. nbusy = MEM_WAIT cycles that see BUSYWAIT high.
    task automatic run(input int op, input int nbusy, input string tag);
        bit   mem, load, b;
        vec_t ctl, e, w;
        logic [31:0] ins;
        logic [7:0]  opb;
        opb = 8'(op);
        ins = {opb, 24'($urandom)};
        ctl = ref_ctrl(op, mem, load);
        if (!mem) begin
            e = ctl; e.pc = 1; e.tmo = tmo_m;
            cyc(1'b1, ins, 1'($urandom), 1'b0, e, {tag, "_exec"});
            busy_cyc(idle_vec(), {tag, "_idle"});
        end else begin
            e = ctl; e.tmo = tmo_m;
            cyc(1'b1, ins, 1'($urandom), 1'b0, e, {tag, "_exec"});
            busy_cyc(e, {tag, "_wait"});
            for (int k = 1; k <= T; k++) begin
                b = (k <= nbusy);
                if (!b || k == T) begin
                    if (b) tmo_m = 1'b1;
                    w = ctl; w.rd = 0; w.wr = 0; w.we = load && !b; w.pc = 1; w.tmo = tmo_m;
                    cyc(1'($urandom), $urandom, b, 1'b0, w, {tag, "_wb"});
                    break;
                end
                cyc(1'($urandom), $urandom, b, 1'b0, e, {tag, "_wait"});
            end
            busy_cyc(idle_vec(), {tag, "_idle"});
        end
    endtask

    task automatic do_reset(input string tag);
        tmo_m = 1'b0;
        cyc(1'b1, $urandom, 1'b1, 1'b1, idle_vec(), tag);
        cyc(1'b0, $urandom, 1'b0, 1'b0, idle_vec(), {tag, "_idle"});
    endtask

    initial begin
        vec_t e;
        bit   mem, load;
        int   op;
        reset = 1'b1; instr_valid = 1'b0; instruction = '0; busywait = 1'b0;
        do_reset("reset");

        run(8'h02, 0, "add");
        run(8'h08, 2, "lwd_busy");
        run(8'h08, 0, "lwd_fast");
        run(8'h0B, 99, "swi_stuck");
        run(8'h01, 0, "mov_sticky_tmo");
        run(8'h0E, 0, "sra");
        run(8'h0C, 0, "bne");
        run(8'h09, T - 1, "lwi_last_chance");

        // reset during MEM_WAIT of lwi
        e = ref_ctrl(9, mem, load); e.tmo = tmo_m;
        cyc(1'b1, 32'h09123456, 1'b1, 1'b0, e, "lwi_rst_exec");
        busy_cyc(e, "lwi_rst_wait");
        cyc(1'b0, $urandom, 1'b1, 1'b0, e, "lwi_rst_wait2");
        do_reset("lwi_rst");

`ifndef MULTICYCLE_CU_ILLEGAL_TRAP_EN
        run(8'hFF, 0, "undef_nop");
`endif

        for (int i = 0; i < 200; i++) begin
`ifdef MULTICYCLE_CU_ILLEGAL_TRAP_EN
            op = int'($urandom_range(0, 17));
`else
            op = ($urandom_range(0, 3) == 0) ? int'($urandom_range(18, 255)) : int'($urandom_range(0, 17));
`endif
            run(op, int'($urandom_range(0, T + 2)), $sformatf("rnd%0d_op%0h", i, op));
            if ($urandom_range(0, 3) == 0)
                cyc(1'b0, $urandom, 1'($urandom), 1'b0, idle_vec(), "rnd_gap");
            if ($urandom_range(0, 30) == 0) do_reset("rnd_reset");
        end

`ifdef MULTICYCLE_CU_ILLEGAL_TRAP_EN
        e = '0; e.tmo = tmo_m;
        cyc(1'b1, 32'hFF00_0000, 1'b0, 1'b0, e, "illegal_exec");
        e.ill = 1;
        for (int i = 0; i < 20; i++) busy_cyc(e, "halt");
        do_reset("halt_reset");
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
